// File: rtl/fpu_pkg.sv
// Shared FPU constants and the iterative divider's state encoding.
package fpu_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    // Quotient bits produced by the restoring divider: 1 integer bit + 24 fraction bits.
    localparam int QBITS = 25;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        NORM   = 2'd2
    } div_state_e;

endpackage

// File: rtl/fp_mant_div_step.sv
// One restoring-division iteration: compare, conditionally subtract, shift left.
module fp_mant_div_step (
    input  logic [24:0] r_i,
    input  logic [23:0] mb_i,
    output logic        q_bit_o,
    output logic [24:0] r_next_o
);

    logic [24:0] r_diff;

    always_comb begin
        q_bit_o  = (r_i >= {1'b0, mb_i});
        r_diff   = q_bit_o ? (r_i - {1'b0, mb_i}) : r_i;
        // The partial remainder is always below Mb here, so the shifted-out MSB is zero.
        r_next_o = r_diff << 1;
    end

endmodule

// File: rtl/fp_divider_iterative.sv
// Sequential single-precision divider: 25-cycle restoring mantissa divide, then truncating normalise.
module fp_divider_iterative #(
    parameter int XLEN = 32,
    parameter int BIAS = 127
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            div_by_zero
);

    import fpu_pkg::*;

    div_state_e         state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic signed [9:0]  e_q, e_d;
    logic               a_zero_q, a_zero_d;
    logic               b_zero_q, b_zero_d;
    logic [24:0]        r_q, r_d;
    logic [24:0]        q_q, q_d;
    logic [23:0]        mb_q, mb_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic               dbz_q, dbz_d;
    logic               done_q, done_d;

    logic               step_q_bit;
    logic [24:0]        step_r_next;
    logic signed [9:0]  exp_n;
    logic [MAN_W-1:0]   mant_n;

    fp_mant_div_step u_step (
        .r_i      (r_q),
        .mb_i     (mb_q),
        .q_bit_o  (step_q_bit),
        .r_next_o (step_r_next)
    );

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        e_d      = e_q;
        a_zero_d = a_zero_q;
        b_zero_d = b_zero_q;
        r_d      = r_q;
        q_d      = q_q;
        mb_d     = mb_q;
        result_d = result_q;
        dbz_d    = dbz_q;
        done_d   = 1'b0;

        exp_n  = q_q[QBITS-1] ? e_q : e_q - 10'sd1;
        mant_n = q_q[QBITS-1] ? q_q[MAN_W:1] : q_q[MAN_W-1:0];

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d   = A[XLEN-1] ^ B[XLEN-1];
                    e_d      = $signed({2'b00, A[MAN_W +: EXP_W]})
                             - $signed({2'b00, B[MAN_W +: EXP_W]}) + 10'(BIAS);
                    a_zero_d = (A[MAN_W +: EXP_W] == '0);
                    b_zero_d = (B[MAN_W +: EXP_W] == '0);
                    r_d      = {2'b01, A[MAN_W-1:0]};
                    mb_d     = {1'b1, B[MAN_W-1:0]};
                    q_d      = '0;
                    cnt_d    = '0;
                    state_d  = DIVIDE;
                end
            end
            DIVIDE: begin
                r_d   = step_r_next;
                q_d   = {q_q[QBITS-2:0], step_q_bit};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(QBITS - 1)) state_d = NORM;
            end
            NORM: begin
                done_d  = 1'b1;
                state_d = IDLE;
                dbz_d   = 1'b0;
                if (b_zero_q) begin
                    result_d = {sign_q, EXP_MAX, {MAN_W{1'b0}}};
                    dbz_d    = 1'b1;
                end else if (a_zero_q || exp_n <= 10'sd0) begin
                    result_d = {sign_q, {(XLEN-1){1'b0}}};
                end else if (exp_n >= 10'sd255) begin
                    result_d = {sign_q, EXP_MAX, {MAN_W{1'b0}}};
                end else begin
                    result_d = {sign_q, exp_n[EXP_W-1:0], mant_n};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            e_q      <= '0;
            a_zero_q <= 1'b0;
            b_zero_q <= 1'b0;
            r_q      <= '0;
            q_q      <= '0;
            mb_q     <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            e_q      <= e_d;
            a_zero_q <= a_zero_d;
            b_zero_q <= b_zero_d;
            r_q      <= r_d;
            q_q      <= q_d;
            mb_q     <= mb_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
            done_q   <= done_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fp_divider_iterative.sv
// Bench for fp_divider_iterative: directed cases, control corner cases and random operands vs. an arithmetic model.
module tb_fp_divider_iterative;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] A, B;
    logic        busy, done, div_by_zero;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fp_divider_iterative #(.XLEN(32), .BIAS(127)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Quotient of the full significands via integer division, then truncating normalise.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic dbz);
        logic            s;
        int              ea, eb, e;
        longint unsigned ma, mb, q;
        logic [22:0]     m;
        s   = a[31] ^ b[31];
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        dbz = 1'b0;
        if (eb == 0) begin
            r   = {s, 8'hFF, 23'h0};
            dbz = 1'b1;
        end else if (ea == 0) begin
            r = {s, 31'h0};
        end else begin
            ma = {40'h0, 1'b1, a[22:0]};
            mb = {40'h0, 1'b1, b[22:0]};
            q  = (ma << 24) / mb;
            if (q >= (64'd1 << 24)) begin
                m = 23'(q >> 1);
                e = ea - eb + 127;
            end else begin
                m = 23'(q);
                e = ea - eb + 126;
            end
            if (e <= 0)        r = {s, 31'h0};
            else if (e >= 255) r = {s, 8'hFF, 23'h0};
            else               r = {s, 8'(e), m};
        end
    endfunction

    // Called just after a falling edge; returns just after the falling edge of the done cycle.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_r;
        logic        exp_dbz;
        logic        busy_ok;
        int          lat;
        ref_div(a, b, exp_r, exp_dbz);
        A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_done_low_after_accept"}, {31'h0, done}, 32'h0);
        lat = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 60) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_busy_during"}, {31'h0, busy_ok}, 32'h1);
        chk({tag, "_latency"}, lat, 32'd27);
        chk({tag, "_busy_in_done"}, {31'h0, busy}, 32'h0);
        chk({tag, "_result"}, result, exp_r);
        chk({tag, "_dbz"}, {31'h0, div_by_zero}, {31'h0, exp_dbz});
    endtask

    initial begin
        logic [31:0] exp_r, held, ra, rb;
        logic        exp_dbz;
        int          lat, extra_done;

        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",   {31'h0, busy}, 32'h0);
        chk("rst_done",   {31'h0, done}, 32'h0);
        chk("rst_result", result, 32'h0);
        chk("rst_dbz",    {31'h0, div_by_zero}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        do_op("six_by_two", 32'h40C00000, 32'h40000000);
        chk("six_by_two_const", result, 32'h40400000);
        held = result;
        repeat (4) @(negedge clk);
        chk("done_pulse_width", {31'h0, done}, 32'h0);
        chk("result_held", result, held);

        do_op("one_third", 32'h3F800000, 32'h40400000);
        chk("one_third_const", result, 32'h3EAAAAAA);
        do_op("neg_eight_by_two", 32'hC1000000, 32'h40000000);
        chk("neg_eight_by_two_const", result, 32'hC0800000);
        do_op("div_pos_zero", 32'h3F800000, 32'h00000000);
        chk("div_pos_zero_const", result, 32'h7F800000);
        do_op("div_neg_zero", 32'h3F800000, 32'h80000000);
        chk("div_neg_zero_const", result, 32'hFF800000);
        do_op("zero_by_zero", 32'h00000000, 32'h00000000);
        do_op("zero_dividend", 32'h80000000, 32'h40000000);
        do_op("overflow", 32'h7F000000, 32'h3E800000);
        chk("overflow_const", result, 32'h7F800000);
        do_op("underflow", 32'h01000000, 32'h7F000000);
        chk("underflow_const", result, 32'h00000000);
        @(negedge clk);

        // start pulsed at N+5 while busy must not disturb the running operation
        ref_div(32'h40C00000, 32'h40000000, exp_r, exp_dbz);
        A = 32'h40C00000; B = 32'h40000000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        A = 32'h3F800000; B = 32'h40400000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 6;
        while (done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("ignored_start_latency", lat, 32'd27);
        chk("ignored_start_result", result, exp_r);
        extra_done = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) extra_done++;
        end
        chk("ignored_start_no_second_done", extra_done, 32'd0);

        // reset at N+10 aborts; restart at N+12 completes at N+39
        A = 32'h40C00000; B = 32'h40000000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy",   {31'h0, busy}, 32'h0);
        chk("midrst_done",   {31'h0, done}, 32'h0);
        chk("midrst_result", result, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        do_op("after_reset", 32'hC1000000, 32'h40000000);

        // back-to-back: each start coincides with the previous done
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 2 == 0) begin
                ra[30:23] = 8'($urandom_range(100, 154));
                rb[30:23] = 8'($urandom_range(100, 154));
            end
            do_op($sformatf("rand%0d", i), ra, rb);
        end
        @(negedge clk);
        chk("final_idle", {31'h0, busy}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_divider_iterative.md
Name: fp_divider_iterative

Overview:
- Sequential IEEE-754 single-precision divider (result = A / B); the inverse companion of the FPU's combinational multiplier.
- Mantissa quotient is produced by a restoring divider, one bit per clock.
- Start/done handshake, fixed latency, truncating (no rounding) to match multiplier numerics.
- Sits in the FPU beside the adder and multiplier; the FPU top selects its result on done.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- BIAS, 127, exponent bias.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  XLEN  dividend; captured on accepted start.
- B  input  XLEN  divisor; captured on accepted start.
- busy  output  1  high from the cycle after accept until done.
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  quotient; held until next done.
- div_by_zero  output  1  flag for the current result; updates with done.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE; busy=0, done=0, result=0, div_by_zero=0.
- Reset mid-operation: aborts the operation; no done pulse; next start is accepted normally.
- States: IDLE -> DIVIDE (25 cycles, iteration counter 0..24) -> NORM (1 cycle) -> IDLE.
- IDLE with start=1 (cycle N):
  - Register sign = A[31]^B[31].
  - Ma = {1,A[22:0]}, Mb = {1,B[22:0]}.
  - 10-bit signed exponent E = A[30:23] - B[30:23] + BIAS.
  - Special flags: a_zero = (A[30:23]==0); b_zero = (B[30:23]==0).
  - Remainder R (25 bits) = Ma; go to DIVIDE.
- start is ignored when not in IDLE. done and start may coincide; start in IDLE on the cycle after done is accepted.
- DIVIDE, each cycle:
  - If R >= Mb: q bit = 1, R = R - Mb; else q bit = 0.
  - Then R = R << 1; q shifts left, MSB first, into q[24:0].
  - After 25 cycles go to NORM.
- NORM (compute result; registered, visible in cycle N+27 together with done=1):
  - If q[24]=1: mant = q[23:1], exp = E. Else: mant = q[22:0], exp = E - 1.
  - exp <= 0: result = {sign, 8'h00, 23'h0} (flush to zero).
  - exp >= 255: result = {sign, 8'hFF, 23'h0} (infinity).
  - Else: result = {sign, exp[7:0], mant}.
  - Remainder is discarded; truncation only, no sticky/rounding.
- Special-case precedence (fixed 27-cycle latency regardless):
  - b_zero: result = {sign, 8'hFF, 23'h0}, div_by_zero=1 (including A zero).
  - else a_zero: result = {sign, 31'h0}, div_by_zero=0.
  - Exponent 255 inputs are not treated specially (numerically processed like the multiplier).
- busy: high cycles N+1 .. N+26; low in the done cycle.
- done: exactly one cycle.

Decomposition:
- Shared package fpu_pkg holds:
  - EXP_W=8, MAN_W=23, BIAS=127, EXP_MAX=8'hFF.
  - Divider state enum {IDLE, DIVIDE, NORM}.
  - QBITS=25.
- One natural sub-module: fp_mant_div_step, a combinational single iteration.
  - Inputs R, Mb.
  - Outputs q_bit and next R (compare, subtract, shift).

Test Plan:
- 6.0/2.0: A=0x40C00000, B=0x40000000, start at N -> done at N+27, result=0x40400000, div_by_zero=0, busy high N+1..N+26.
- 1.0/3.0: A=0x3F800000, B=0x40400000 -> result=0x3EAAAAAA (truncated, not 0x3EAAAAAB).
- Sign handling: 0xC1000000 / 0x40000000 -> 0xC0800000 (-4.0).
- Divide by zero: 0x3F800000 / 0x00000000 -> 0x7F800000, div_by_zero=1. Same A with B=0x80000000 -> 0xFF800000, div_by_zero=1.
- Exponent range:
  - 0x7F000000 / 0x3E800000 -> 0x7F800000, div_by_zero=0.
  - 0x01000000 / 0x7F000000 -> 0x00000000.
- Control:
  - start pulsed at N+5 while busy -> ignored; single done at N+27.
  - rst at N+10 -> busy=0, done=0, result=0 next cycle, no done pulse.
  - New start at N+12 -> done at N+39 with correct result.
